// File: rtl/mac_serial_feeder.sv
// Upstream sequencer for top_mac_serial: takes parallel (w, a) operands and streams w as
// N_WIDTH-bit digits, LSB first, with the accumulator control strobes and a result-valid pulse.
module mac_serial_feeder #(
    parameter int W_WIDTH        = 8,
    parameter int A_WIDTH        = 8,
    parameter int N_WIDTH        = 2,
    parameter int CONFIG_W_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_W_WIDTH-1:0] config_w,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W_WIDTH-1:0]        in_w,
    input  logic [A_WIDTH-1:0]        in_a,
    input  logic                      in_last,
    output logic                      mac_rst,
    output logic [N_WIDTH-1:0]        w_serial,
    output logic [A_WIDTH-1:0]        a,
    output logic                      fsm_accu,
    output logic                      fsm_last,
    output logic                      trigger_accu,
    output logic                      z_valid
);

    localparam int MAX_DIG = W_WIDTH / N_WIDTH;
    localparam int MIN_DIG = (MAX_DIG >= 4) ? MAX_DIG / 4 : 1;
    localparam int DW      = (MAX_DIG > 1) ? $clog2(MAX_DIG) : 1;

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_FLUSH0 = 3'd3;
    localparam logic [2:0] S_FLUSH1 = 3'd4;

    // Index of the final digit for the latched precision.
    function automatic logic [DW-1:0] last_digit(input logic [CONFIG_W_WIDTH-1:0] c);
        case (c)
            0:       return DW'(MAX_DIG - 1);
            1:       return DW'(MAX_DIG / 2 - 1);
            default: return DW'(MIN_DIG - 1);
        endcase
    endfunction

    // Drops the zero-padded LSBs so digit 0 is the LSB of the active weight.
    function automatic logic [W_WIDTH-1:0] align_w(input logic [W_WIDTH-1:0] w,
                                                   input logic [CONFIG_W_WIDTH-1:0] c);
        case (c)
            0:       return w;
            1:       return w >> (W_WIDTH / 2);
            default: return w >> (W_WIDTH - W_WIDTH / 4);
        endcase
    endfunction

    logic [2:0]                state_p0;
    logic [DW-1:0]             dig_p0;
    logic [CONFIG_W_WIDTH-1:0] cfg_p0;
    logic                      last_op_p0;
    logic [W_WIDTH-1:0]        sreg_p0;

    logic [DW-1:0]      ndig_m1;
    logic [DW-1:0]      dig_nxt;
    logic [W_WIDTH-1:0] w_load;
    logic               at_last_dig;
    logic               do_load;

    always_comb begin
        ndig_m1     = last_digit(cfg_p0);
        dig_nxt     = dig_p0 + DW'(1);
        w_load      = align_w(in_w, cfg_p0);
        at_last_dig = (dig_p0 == ndig_m1);
        do_load     = in_valid && in_ready &&
                      ((state_p0 == S_WAIT) || ((state_p0 == S_SHIFT) && at_last_dig && !last_op_p0));
    end

    // Stage p0: control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= S_CLEAR;
            dig_p0       <= '0;
            cfg_p0       <= '0;
            last_op_p0   <= 1'b0;
            mac_rst      <= 1'b1;
            in_ready     <= 1'b0;
            w_serial     <= '0;
            a            <= '0;
            fsm_accu     <= 1'b0;
            fsm_last     <= 1'b0;
            trigger_accu <= 1'b0;
            z_valid      <= 1'b0;
        end else begin
            mac_rst      <= 1'b0;
            in_ready     <= 1'b0;
            w_serial     <= '0;
            fsm_accu     <= 1'b0;
            fsm_last     <= 1'b0;
            trigger_accu <= 1'b0;
            z_valid      <= 1'b0;
            if (do_load) begin
                state_p0     <= S_SHIFT;
                dig_p0       <= '0;
                last_op_p0   <= in_last;
                a            <= in_a;
                w_serial     <= w_load[N_WIDTH-1:0];
                fsm_accu     <= 1'b1;
                fsm_last     <= (ndig_m1 == '0);
                trigger_accu <= (ndig_m1 == '0);
                in_ready     <= (ndig_m1 == '0) && !in_last;
            end else begin
                case (state_p0)
                    S_CLEAR: begin
                        cfg_p0   <= config_w;
                        in_ready <= 1'b1;
                        state_p0 <= S_WAIT;
                    end
                    S_WAIT: in_ready <= 1'b1;
                    S_SHIFT: begin
                        if (at_last_dig) begin
                            if (last_op_p0) begin
                                state_p0 <= S_FLUSH0;
                            end else begin
                                state_p0 <= S_WAIT;
                                in_ready <= 1'b1;
                            end
                        end else begin
                            dig_p0       <= dig_nxt;
                            w_serial     <= sreg_p0[N_WIDTH-1:0];
                            fsm_last     <= (dig_nxt == ndig_m1);
                            trigger_accu <= (dig_p0 == '0);
                            in_ready     <= (dig_nxt == ndig_m1) && !last_op_p0;
                        end
                    end
                    // Hold off the clear until the MAC has produced the final sum.
                    S_FLUSH0: begin
                        state_p0 <= S_FLUSH1;
                        z_valid  <= 1'b1;
                    end
                    S_FLUSH1: begin
                        state_p0 <= S_CLEAR;
                        mac_rst  <= 1'b1;
                    end
                    default: begin
                        state_p0 <= S_CLEAR;
                        mac_rst  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Stage p0 datapath: remaining digits of the operand in flight.
    always_ff @(posedge clk) begin
        if (do_load) begin
            sreg_p0 <= w_load >> N_WIDTH;
        end else if ((state_p0 == S_SHIFT) && !at_last_dig) begin
            sreg_p0 <= sreg_p0 >> N_WIDTH;
        end
    end

endmodule

// File: tb/tb_mac_serial_feeder.sv
// Randomized scoreboard bench for mac_serial_feeder; a monitor rebuilds the MAC sum from the
// digit stream and compares digits and final sums with an arithmetic reference model.
module tb_mac_serial_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] config_w = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_w = 8'd0;
    logic [7:0] in_a = 8'd0;
    logic       in_last = 1'b0;
    logic       mac_rst;
    logic [1:0] w_serial;
    logic [7:0] a;
    logic       fsm_accu, fsm_last, trigger_accu, z_valid;

    mac_serial_feeder dut (
        .clk(clk), .rst(rst), .config_w(config_w),
        .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a), .in_last(in_last),
        .mac_rst(mac_rst), .w_serial(w_serial), .a(a), .fsm_accu(fsm_accu),
        .fsm_last(fsm_last), .trigger_accu(trigger_accu), .z_valid(z_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              ndig;
        logic [3:0][1:0] dig;
        logic [7:0]      av;
        logic            last;
    } op_t;

    op_t opq[$];
    int  zq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  cur_cfg = 0;
    int  acc_z = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wact_of(input int c);
        return (c == 0) ? 8 : (c == 1) ? 4 : 2;
    endfunction

    function automatic logic [7:0] mask_w(input logic [7:0] w, input int c);
        logic [7:0] m;
        m = 8'hFF << (8 - wact_of(c));
        return w & m;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_op(input logic [7:0] w, input logic [7:0] av, input bit last,
                           output int acc_cyc);
        op_t r;
        int  shift, u, sw;
        in_valid = 1'b1; in_w = w; in_a = av; in_last = last;
        acc_cyc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                shift  = 8 - wact_of(cur_cfg);
                u      = int'(w) / (1 << shift);
                r.ndig = wact_of(cur_cfg) / 2;
                for (int i = 0; i < 4; i++) r.dig[i] = 2'((u / (1 << (2 * i))) % 4);
                r.av   = av;
                r.last = last;
                opq.push_back(r);
                sw = int'($signed(w));
                acc_z += (sw / (1 << shift)) * int'(av);
                if (last) begin
                    zq.push_back(acc_z);
                    acc_z   = 0;
                    cur_cfg = int'(config_w);
                end
                acc_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc_cyc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never seen for w=%0h", w);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        opq.delete(); zq.delete();
        acc_z = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mac_rst", mac_rst, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_w_serial", w_serial, 0);
        chk("rst_a", a, 0);
        chk("rst_flags", {fsm_accu, fsm_last, trigger_accu, z_valid}, 0);
        @(posedge clk); #1;
        cur_cfg = int'(config_w);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: downstream MAC reconstruction and per-cycle checks.
    bit     in_run = 0;
    bit     zpend = 0;
    int     zdue = 0;
    int     idx = 0;
    int     opval = 0;
    longint z_recon = 0;
    op_t    cur;

    always @(negedge clk) begin
        int d;
        if (rst) begin
            in_run  = 0;
            zpend   = 0;
            z_recon = 0;
        end else begin
            if (mac_rst) begin
                chk("mac_rst_while_busy", in_run || zpend, 0);
                z_recon = 0;
            end
            if (!in_run && fsm_accu) begin
                if (opq.size() == 0) begin
                    chk("unexpected_operand", 1, 0);
                end else begin
                    cur    = opq.pop_front();
                    in_run = 1; idx = 0; opval = 0;
                end
            end
            if (in_run) begin
                chk("w_serial", w_serial, cur.dig[idx]);
                chk("a", a, cur.av);
                chk("fsm_accu", fsm_accu, idx == 0);
                chk("fsm_last", fsm_last, idx == cur.ndig - 1);
                chk("trigger_accu", trigger_accu, (idx == 1) || (cur.ndig == 1));
                d = int'(w_serial);
                if (idx == cur.ndig - 1 && d >= 2) d -= 4;
                opval += d * (1 << (2 * idx));
                idx++;
                if (idx == cur.ndig) begin
                    in_run = 0;
                    z_recon += longint'(opval) * longint'(a);
                    if (cur.last) begin
                        zpend = 1;
                        zdue  = cyc + 2;
                    end
                end
            end else begin
                chk("idle_w_serial", w_serial, 0);
                chk("idle_flags", {fsm_last, trigger_accu}, 0);
            end
            if (z_valid) begin
                chk("z_valid_timing", cyc, zpend ? zdue : -1);
                if (zpend && zq.size() > 0) chk("z_value", z_recon, zq.pop_front());
                zpend = 0;
            end else if (zpend && cyc == zdue) begin
                chk("z_valid_missing", z_valid, 1);
                zpend = 0;
            end
        end
    end

    initial begin
        int c0, c1, cn;
        logic [7:0] w;
        // 8-bit precision, single operand
        config_w = 2'd0;
        do_reset();
        idle(2);
        send_op(8'h7F, 8'd3, 1'b1, c0);
        idle(8);

        // 4-bit precision, back-to-back pair
        config_w = 2'd1;
        do_reset();
        send_op(8'hA0, 8'd5, 1'b0, c0);
        send_op(8'h30, 8'd2, 1'b1, c1);
        chk("b2b_4b_spacing", c1 - c0, 2);
        idle(8);

        // 2-bit precision, 50 back-to-back operands
        config_w = 2'd3;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            send_op(8'h40, 8'd1, i == 49, cn);
            if (i == 0) c0 = cn;
        end
        chk("b2b_2b_spacing", cn - c0, 49);
        idle(8);

        // Bubbles between 8-bit operands
        config_w = 2'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_op(8'($urandom), 8'($urandom), i == 2, c0);
            idle(7);
        end
        idle(6);

        // Precision change mid-accumulation takes effect only on the next one
        send_op(8'($urandom), 8'($urandom), 1'b0, c0);
        config_w = 2'd1;
        send_op(8'($urandom), 8'($urandom), 1'b0, c0);
        send_op(8'h81, 8'd200, 1'b1, c0);
        send_op(mask_w(8'($urandom), 1), 8'($urandom), 1'b0, c0);
        send_op(mask_w(8'($urandom), 1), 8'($urandom), 1'b1, c0);
        idle(8);

        // Reset during digit 1 of an 8-bit last operand, then a fresh accumulation
        config_w = 2'd0;
        do_reset();
        send_op(8'h55, 8'd7, 1'b1, c0);
        do_reset();
        send_op(8'h80, 8'd255, 1'b1, c0);
        idle(8);

        // Random accumulations
        for (int k = 0; k < 6; k++) begin
            config_w = 2'($urandom_range(0, 3));
            do_reset();
            for (int j = 0; j < 2; j++) begin
                cn = $urandom_range(1, 6);
                for (int i = 0; i < cn; i++) begin
                    w = mask_w(8'($urandom), cur_cfg);
                    send_op(w, 8'($urandom), i == cn - 1, c0);
                    idle($urandom_range(0, 3));
                end
            end
            idle(6);
        end

        idle(20);
        chk("ops_left", opq.size(), 0);
        chk("z_left", zq.size(), 0);
        chk("z_pending", zpend, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
